// File: rtl/nibble_serial_addsub_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor.
// The state encoding, slice width and counter sizing live here so that the
// top level and the slice agree on them.
package addsub_pkg;

    // Width of the ripple-carry slice. One nibble is processed per clock.
    localparam int NIBBLE = 4;

    // Controller states. The encodings are fixed so that they stay stable
    // if a debug port is ever brought out.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Returns the number of bits needed to index 'value' items. The result is
    // never less than 1, so that a counter always has at least one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/nibble_serial_addsub_nibble_adder.sv
// Four-bit ripple-carry slice. The top level reuses this single slice for
// every nibble of the wide operands.
module nibble_adder
    import addsub_pkg::*;
(
    input  logic [NIBBLE-1:0] a,
    input  logic [NIBBLE-1:0] b,
    input  logic              ci,
    output logic [NIBBLE-1:0] s,
    output logic              co
);

    logic [NIBBLE:0] w_carry;

    assign w_carry[0] = ci;

    // Full-adder chain. Each bit passes its carry to the bit above it.
    for (genvar i = 0; i < NIBBLE; i++) begin : g_bit
        assign s[i]         = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign co = w_carry[NIBBLE];

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor built around one 4-bit slice.
// The block latches the operands when a request is accepted. It then feeds
// one nibble per clock through the slice, least significant nibble first,
// and carries between nibbles in a flop. The result is written in place, and
// the flags are produced on the final nibble.
module nibble_serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int              N    = WIDTH / NIBBLE;
    localparam int              CW   = clog2(N);
    localparam logic [CW-1:0]   LAST = CW'(N - 1);

    state_t            r_state;
    state_t            w_nextState;
    logic              w_accept;
    logic              w_running;
    logic              w_lastNibble;

    logic [WIDTH-1:0]  r_opA;
    logic [WIDTH-1:0]  r_opB;
    logic              r_carry;
    logic [CW-1:0]     r_count;

    logic [WIDTH-1:0]  r_result;
    logic              r_carryOut;
    logic              r_overflow;

    logic [NIBBLE-1:0] w_nibA;
    logic [NIBBLE-1:0] w_nibB;
    logic [NIBBLE-1:0] w_sum;
    logic              w_sliceCo;

    assign w_running    = (r_state == ST_RUN);
    assign w_lastNibble = w_running && (r_count == LAST);

    // Next-state logic. A request is accepted from IDLE, and also from DONE,
    // so that back-to-back operations lose no extra cycle. While RUN is
    // active, start is ignored.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_lastNibble) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_nextState = ST_RUN;
                end else begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // State register. A reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Operand capture. B is stored already inverted for subtraction, so the
    // slice only ever adds. The +1 comes in through the initial carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opA <= '0;
            r_opB <= '0;
        end else if (w_accept) begin
            r_opA <= a;
            r_opB <= sub ? ~b : b;
        end
    end

    // Inter-nibble carry and nibble index. The index returns to zero when the
    // last nibble is done, so it never holds a value past the last nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
            r_count <= '0;
        end else if (w_accept) begin
            r_carry <= sub;
            r_count <= '0;
        end else if (w_running) begin
            r_carry <= w_sliceCo;
            r_count <= w_lastNibble ? '0 : r_count + CW'(1);
        end
    end

    // Nibble select. Picks the operand nibbles addressed by the current index.
    always_comb begin
        w_nibA = '0;
        w_nibB = '0;
        for (int k = 0; k < N; k++) begin
            if (r_count == CW'(k)) begin
                w_nibA = r_opA[k*NIBBLE +: NIBBLE];
                w_nibB = r_opB[k*NIBBLE +: NIBBLE];
            end
        end
    end

    nibble_adder u_slice (
        .a  (w_nibA),
        .b  (w_nibB),
        .ci (r_carry),
        .s  (w_sum),
        .co (w_sliceCo)
    );

    // Result assembly. Only the nibble addressed by the index is written in
    // each RUN cycle. The other nibbles keep their values, so the result stays
    // stable through IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
        end else if (w_running) begin
            for (int k = 0; k < N; k++) begin
                if (r_count == CW'(k)) begin
                    r_result[k*NIBBLE +: NIBBLE] <= w_sum;
                end
            end
        end
    end

    // Flags, taken on the final nibble. Signed overflow means both addends
    // had the same sign and the sum's sign differs from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carryOut <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_lastNibble) begin
            r_carryOut <= w_sliceCo;
            r_overflow <= (r_opA[WIDTH-1] == r_opB[WIDTH-1]) &&
                          (w_sum[NIBBLE-1] != r_opA[WIDTH-1]);
        end
    end

    assign busy      = w_running;
    assign done      = (r_state == ST_DONE);
    assign result    = r_result;
    assign carry_out = r_carryOut;
    assign overflow  = r_overflow;

endmodule
